ds1620_responder: RTL and testbench
===================================

// Module: ds1620_responder
// PURPOSE
//  Synthesizable DS1620-style 3-wire slave: the device end of the link driven by DS1620_INTERFACE.
//  Oversamples DS_CLK/DS_RST/DQ_IN on the fast system clock and decodes 8-bit LSB-first commands.
//  Returns 9-bit temperature / 8-bit config LSB-first; holds a config register and a conversion engine.
//  Used as an on-board emulator and as a bench partner for the interface master.
// PARAMETERS
//  SYNC_STAGES  2      flops per input synchronizer (>=2)
//  CONV_CYCLES  750    system clocks per temperature conversion
//  TEMP_W       9      temperature width, two's complement, 0.5 C/LSB
// PORTS
//  CLK_IN    in   1       system clock, single domain; must be >= 2*(SYNC_STAGES+2) x DS_CLK rate
//  CLR       in   1       asynchronous active-high reset
//  DS_CLK    in   1       3-wire serial clock from master
//  DS_RST    in   1       3-wire enable from master; high = transfer active
//  DQ_IN     in   1       DQ pin value (master -> responder)
//  TEMP_SET  in   TEMP_W  emulated sensor value, sampled at end of each conversion
//  DQ_OUT    out  1       DQ value driven when TRI_EN=1
//  TRI_EN    out  1       responder owns DQ
//  CMD       out  8       last complete command byte
//  CMD_STB   out  1       1-cycle pulse when CMD updates
//  CONV_RUN  out  1       conversion engine running
//  THIGH     out  1       temp >= TH (0 when thermostat compiled out)
//  TLOW      out  1       temp <= TL (0 when thermostat compiled out)
// BEHAVIOUR
//  Reset: DQ_OUT=0 TRI_EN=0 CMD=0 CMD_STB=0 CONV_RUN=0 THIGH=0 TLOW=0; state IDLE; TEMP_REG=0; CFG=8'h00.
//  Inputs pass SYNC_STAGES flops, then edge detect; every action fires 1 clk after detected edge
//   (pin edge -> effect = SYNC_STAGES+1 clocks).
//  States: IDLE -> CMD (DS_RST rise) -> WR | RD | DONE -> IDLE (DS_RST fall).
//  CMD: sample DQ on each DS_CLK rise, shift LSB-first; 8th rise -> CMD, CMD_STB, decode:
//   8'hEE start convert: CONV_RUN=1, ->DONE; 8'h22 stop: CONV_RUN=0, ->DONE
//   8'hAA read temp (9b) ->RD; 8'hAC read CFG (8b) ->RD; 8'h0C write CFG (8b) ->WR
//   8'hA1/8'hA2 read TH/TL, 8'h01/8'h02 write TH/TL (9b) when THERMOSTAT_EN, else unknown
//   unknown opcode -> DONE (ignored, CMD/CMD_STB still update)
//  RD: snapshot data at decode; on each DS_CLK fall drive next bit LSB-first, TRI_EN=1 from 1st fall;
//   after last bit's following rise, TRI_EN=0, ->DONE. Extra clocks in DONE: TRI_EN stays 0.
//  WR: sample on DS_CLK rises; register updates only on final bit; CFG write changes bits[1:0] only,
//   writing 0 to bit6/bit5 clears THF/TLF.
//  DS_RST fall in any state: ->IDLE within SYNC_STAGES+1 clocks, TRI_EN=0, bit counter cleared,
//   partial write discarded, conversion unaffected.
//  Conversion: counter counts CONV_CYCLES; at terminal TEMP_REG<=TEMP_SET, CFG[7] DONE=1;
//   if CFG[0] 1SHOT=1, CONV_RUN clears after one conversion, else restarts. DONE clears on 8'hEE.
//  8'hEE while running restarts counter from 0; 8'h22 mid-count aborts, TEMP_REG unchanged.
//  Simultaneous conversion end and RD snapshot: snapshot takes the old TEMP_REG.
// CONFIGURATION
//  `DS1620_THERMOSTAT_EN defined: TH/TL 9b regs (reset TH=9'h0F0, TL=9'h1F6), commands above;
//   THIGH/TLOW signed-compare TEMP_REG each clock; sticky CFG[6] THF / CFG[5] TLF set on flag.
//  Not defined: no TH/TL storage, their opcodes treated as unknown, THIGH=TLOW=0, CFG[6:5]=0.
// STRUCTURE
//  Package ds1620_pkg: opcode localparams, state encoding, CFG bit indices, TH/TL reset values.
//  Sub-module ds1620_sync_edge: SYNC_STAGES synchronizer + rise/fall pulse, instanced for DS_CLK,
//   DS_RST, DQ_IN. Top holds FSM, shift reg, bit counter, CFG/TEMP/TH/TL, conversion counter.
// TESTING
//  1 CLR 1 clk; TEMP_SET=9'h032; send 8'hEE, wait CONV_CYCLES; 8'hAA -> bits 0,1,0,0,1,1,0,0,0, CMD=8'hAA.
//  2 TEMP_SET=9'h1CE (-25C), convert, 8'hAA -> 9'h1CE; 8'hAC -> 8'h80 (DONE set, 1SHOT=0).
//  3 8'h0C data 8'h03, then 8'hAC -> 8'h83 after conversion; CONV_RUN drops after one conversion.
//  4 DS_RST low after 4 cmd bits -> TRI_EN=0, IDLE in SYNC_STAGES+1 clks; next 8'hAA reads correctly.
//  5 DS_RST low after 5 data bits of 8'h0C -> CFG unchanged; DS_RST low mid-RD -> TRI_EN=0.
//  6 THERMOSTAT_EN: 8'h01 data 9'h028, TEMP=9'h032 -> THIGH=1, CFG[6]=1; 8'hA1 returns 9'h028.

Source files
------------

// File: rtl/ds1620_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ds1620_pkg: opcodes, FSM encoding and CFG layout for the DS1620 responder. Rev 1.0
// ---------------------------------------------------------------------------
package ds1620_pkg;

   localparam logic [7:0] OP_CONVERT = 8'hEE;
   localparam logic [7:0] OP_STOP    = 8'h22;
   localparam logic [7:0] OP_RD_TEMP = 8'hAA;
   localparam logic [7:0] OP_RD_CFG  = 8'hAC;
   localparam logic [7:0] OP_WR_CFG  = 8'h0C;
   localparam logic [7:0] OP_RD_TH   = 8'hA1;
   localparam logic [7:0] OP_RD_TL   = 8'hA2;
   localparam logic [7:0] OP_WR_TH   = 8'h01;
   localparam logic [7:0] OP_WR_TL   = 8'h02;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CMD  = 3'd1;
   localparam logic [2:0] ST_WR   = 3'd2;
   localparam logic [2:0] ST_RD   = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam int CFG_DONE  = 7;
   localparam int CFG_THF   = 6;
   localparam int CFG_TLF   = 5;
   localparam int CFG_1SHOT = 0;

   localparam logic [8:0] TH_RESET = 9'h0F0;
   localparam logic [8:0] TL_RESET = 9'h1F6;

   typedef enum logic [1:0] {
      WR_CFG = 2'd0,
      WR_TH  = 2'd1,
      WR_TL  = 2'd2
   } wr_sel_t;

endpackage
`default_nettype wire

// File: rtl/ds1620_sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ds1620_sync_edge: multi-flop input synchronizer with rise/fall pulses. Rev 1.0
// ---------------------------------------------------------------------------
module ds1620_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], din};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign level = chain[SYNC_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule
`default_nettype wire

// File: rtl/ds1620_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ds1620_responder: DS1620-style 3-wire slave with config register and conversion
// engine. Optional thermostat (TH/TL, THIGH/TLOW) via DS1620_THERMOSTAT_EN. Rev 1.0
// ---------------------------------------------------------------------------
module ds1620_responder
   import ds1620_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CONV_CYCLES = 750,
   parameter int TEMP_W      = 9
) (
   input  logic              CLK_IN,
   input  logic              CLR,
   input  logic              DS_CLK,
   input  logic              DS_RST,
   input  logic              DQ_IN,
   input  logic [TEMP_W-1:0] TEMP_SET,
   output logic              DQ_OUT,
   output logic              TRI_EN,
   output logic [7:0]        CMD,
   output logic              CMD_STB,
   output logic              CONV_RUN,
   output logic              THIGH,
   output logic              TLOW
);

   localparam int SH_W  = (TEMP_W > 8) ? TEMP_W : 8;
   localparam int BC_W  = $clog2(SH_W + 1);
   localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
   localparam logic [BC_W-1:0]  LEN_BYTE  = BC_W'(8);
   localparam logic [BC_W-1:0]  LEN_TEMP  = BC_W'(TEMP_W);
   localparam logic [BC_W-1:0]  LAST_CMD  = BC_W'(7);

   logic clk_lvl, clk_rise, clk_fall;
   logic rst_lvl, rst_rise, rst_fall;
   logic dq_lvl, dq_rise, dq_fall;

   ds1620_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .clk(CLK_IN), .rst(CLR), .din(DS_CLK), .level(clk_lvl), .rise(clk_rise), .fall(clk_fall));
   ds1620_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rst (
      .clk(CLK_IN), .rst(CLR), .din(DS_RST), .level(rst_lvl), .rise(rst_rise), .fall(rst_fall));
   ds1620_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dq (
      .clk(CLK_IN), .rst(CLR), .din(DQ_IN), .level(dq_lvl), .rise(dq_rise), .fall(dq_fall));

   logic [2:0]        state;
   logic [BC_W-1:0]   bit_cnt, xfer_len;
   logic [SH_W-1:0]   shift, rd_data, wr_val;
   wr_sel_t           wr_sel;
   logic [TEMP_W-1:0] temp_reg;
   logic [CNT_W-1:0]  conv_cnt;
   logic [1:0]        cfg_lo;
   logic              cfg_done, thf, tlf;
   logic [7:0]        cfg_val, cmd_byte;
   logic              link_edge, decode, conv_start, conv_stop, wr_done, cfg_wr;
   logic              unused_ok;

`ifdef DS1620_THERMOSTAT_EN
   logic [TEMP_W-1:0] th, tl;
   logic              ge_th, le_tl;
`endif

   assign link_edge  = rst_rise | rst_fall;
   assign cmd_byte   = {dq_lvl, shift[6:0]};
   assign decode     = (state == ST_CMD) && clk_rise && !link_edge && (bit_cnt == LAST_CMD);
   assign conv_start = decode && (cmd_byte == OP_CONVERT);
   assign conv_stop  = decode && (cmd_byte == OP_STOP);
   assign wr_done    = (state == ST_WR) && clk_rise && !link_edge &&
                       (bit_cnt == xfer_len - BC_W'(1));
   assign cfg_wr     = wr_done && (wr_sel == WR_CFG);
   assign cfg_val    = {cfg_done, thf, tlf, 3'b000, cfg_lo};
   assign unused_ok  = ^{clk_lvl, rst_lvl, dq_rise, dq_fall, wr_val};

   // Completed write word: the final bit is taken straight from the pin.
   always_comb begin
      wr_val          = shift;
      wr_val[bit_cnt] = dq_lvl;
   end

   always_ff @(posedge CLK_IN or posedge CLR) begin
      if (CLR) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         xfer_len <= '0;
         shift    <= '0;
         rd_data  <= '0;
         wr_sel   <= WR_CFG;
         DQ_OUT   <= 1'b0;
         TRI_EN   <= 1'b0;
         CMD      <= 8'h00;
         CMD_STB  <= 1'b0;
      end else begin
         CMD_STB <= 1'b0;
         if (rst_fall) begin
            state   <= ST_IDLE;
            TRI_EN  <= 1'b0;
            bit_cnt <= '0;
         end else if (rst_rise) begin
            state   <= ST_CMD;
            TRI_EN  <= 1'b0;
            bit_cnt <= '0;
         end else begin
            case (state)
               ST_CMD: begin
                  if (clk_rise) begin
                     shift[bit_cnt] <= dq_lvl;
                     bit_cnt        <= bit_cnt + BC_W'(1);
                     if (bit_cnt == LAST_CMD) begin
                        CMD     <= cmd_byte;
                        CMD_STB <= 1'b1;
                        bit_cnt <= '0;
                        state   <= ST_DONE;
                        case (cmd_byte)
                           OP_RD_TEMP: begin
                              rd_data  <= SH_W'(temp_reg);
                              xfer_len <= LEN_TEMP;
                              state    <= ST_RD;
                           end
                           OP_RD_CFG: begin
                              rd_data  <= SH_W'(cfg_val);
                              xfer_len <= LEN_BYTE;
                              state    <= ST_RD;
                           end
                           OP_WR_CFG: begin
                              wr_sel   <= WR_CFG;
                              xfer_len <= LEN_BYTE;
                              state    <= ST_WR;
                           end
`ifdef DS1620_THERMOSTAT_EN
                           OP_RD_TH: begin
                              rd_data  <= SH_W'(th);
                              xfer_len <= LEN_TEMP;
                              state    <= ST_RD;
                           end
                           OP_RD_TL: begin
                              rd_data  <= SH_W'(tl);
                              xfer_len <= LEN_TEMP;
                              state    <= ST_RD;
                           end
                           OP_WR_TH: begin
                              wr_sel   <= WR_TH;
                              xfer_len <= LEN_TEMP;
                              state    <= ST_WR;
                           end
                           OP_WR_TL: begin
                              wr_sel   <= WR_TL;
                              xfer_len <= LEN_TEMP;
                              state    <= ST_WR;
                           end
`endif
                           default: ;
                        endcase
                     end
                  end
               end
               ST_WR: begin
                  if (clk_rise) begin
                     shift[bit_cnt] <= dq_lvl;
                     bit_cnt        <= bit_cnt + BC_W'(1);
                     if (wr_done) begin
                        bit_cnt <= '0;
                        state   <= ST_DONE;
                     end
                  end
               end
               // Bits leave on falling edges; the master samples before the next rise.
               ST_RD: begin
                  if (clk_fall && (bit_cnt < xfer_len)) begin
                     DQ_OUT  <= rd_data[bit_cnt];
                     TRI_EN  <= 1'b1;
                     bit_cnt <= bit_cnt + BC_W'(1);
                  end else if (clk_rise && (bit_cnt == xfer_len)) begin
                     TRI_EN  <= 1'b0;
                     bit_cnt <= '0;
                     state   <= ST_DONE;
                  end
               end
               ST_IDLE, ST_DONE: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge CLK_IN or posedge CLR) begin
      if (CLR) begin
         CONV_RUN <= 1'b0;
         conv_cnt <= '0;
         temp_reg <= '0;
         cfg_done <= 1'b0;
         cfg_lo   <= 2'b00;
      end else begin
         if (conv_start) begin
            CONV_RUN <= 1'b1;
            conv_cnt <= '0;
            cfg_done <= 1'b0;
         end else if (conv_stop) begin
            CONV_RUN <= 1'b0;
            conv_cnt <= '0;
         end else if (CONV_RUN) begin
            if (conv_cnt == CONV_LAST) begin
               temp_reg <= TEMP_SET;
               cfg_done <= 1'b1;
               conv_cnt <= '0;
               if (cfg_lo[CFG_1SHOT])
                  CONV_RUN <= 1'b0;
            end else begin
               conv_cnt <= conv_cnt + CNT_W'(1);
            end
         end
         if (cfg_wr)
            cfg_lo <= wr_val[1:0];
      end
   end

`ifdef DS1620_THERMOSTAT_EN
   assign ge_th = $signed(temp_reg) >= $signed(th);
   assign le_tl = $signed(temp_reg) <= $signed(tl);

   // Flags are sticky: a CFG write of 0 clears them, a live compare re-sets them.
   always_ff @(posedge CLK_IN or posedge CLR) begin
      if (CLR) begin
         th    <= TEMP_W'(TH_RESET);
         tl    <= TEMP_W'(TL_RESET);
         thf   <= 1'b0;
         tlf   <= 1'b0;
         THIGH <= 1'b0;
         TLOW  <= 1'b0;
      end else begin
         if (wr_done && (wr_sel == WR_TH))
            th <= wr_val[TEMP_W-1:0];
         if (wr_done && (wr_sel == WR_TL))
            tl <= wr_val[TEMP_W-1:0];
         thf   <= (thf & ~(cfg_wr & ~wr_val[CFG_THF])) | ge_th;
         tlf   <= (tlf & ~(cfg_wr & ~wr_val[CFG_TLF])) | le_tl;
         THIGH <= ge_th;
         TLOW  <= le_tl;
      end
   end
`else
   assign thf   = 1'b0;
   assign tlf   = 1'b0;
   assign THIGH = 1'b0;
   assign TLOW  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ds1620_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ds1620_responder: drives the 3-wire link as a master, checks against a model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_ds1620_responder;

   localparam int SS   = 2;
   localparam int CONV = 300;
   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       clr, ds_clk, ds_rst, dq_in;
   logic [8:0] temp_set;
   logic       dq_out, tri_en, cmd_stb, conv_run, thigh, tlow;
   logic [7:0] cmd;

   int n_cmp = 0;
   int n_err = 0;
   int stb_count = 0;

   // Behavioural model of the device registers
   logic [8:0] m_temp, m_th, m_tl;
   logic [1:0] m_lo;
   logic       m_done, m_run, m_thf, m_tlf;

   ds1620_responder #(.SYNC_STAGES(SS), .CONV_CYCLES(CONV), .TEMP_W(9)) dut (
      .CLK_IN(clk), .CLR(clr), .DS_CLK(ds_clk), .DS_RST(ds_rst), .DQ_IN(dq_in),
      .TEMP_SET(temp_set), .DQ_OUT(dq_out), .TRI_EN(tri_en), .CMD(cmd), .CMD_STB(cmd_stb),
      .CONV_RUN(conv_run), .THIGH(thigh), .TLOW(tlow));

   always #5 clk = ~clk;
   always @(posedge clk) if (cmd_stb === 1'b1) stb_count++;

   function automatic logic [7:0] exp_cfg();
      return {m_done, m_thf, m_tlf, 3'b000, m_lo};
   endfunction

   function automatic void refresh_flags();
`ifdef DS1620_THERMOSTAT_EN
      if ($signed(m_temp) >= $signed(m_th)) m_thf = 1'b1;
      if ($signed(m_temp) <= $signed(m_tl)) m_tlf = 1'b1;
`endif
   endfunction

   function automatic bit is_known(logic [7:0] op);
      bit k = (op == 8'hEE) || (op == 8'h22) || (op == 8'hAA) || (op == 8'hAC) || (op == 8'h0C);
`ifdef DS1620_THERMOSTAT_EN
      if ((op == 8'hA1) || (op == 8'hA2) || (op == 8'h01) || (op == 8'h02)) k = 1'b1;
`endif
      return k;
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic begin_xfer();
      ds_rst = 1'b1;
      wait_clk(HALF);
   endtask

   task automatic end_xfer();
      ds_rst = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic send_bits(input logic [8:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         ds_clk = 1'b0;
         dq_in  = v[i];
         wait_clk(HALF);
         ds_clk = 1'b1;
         wait_clk(HALF);
      end
   endtask

   task automatic read_bits(input int n, output logic [8:0] v, output int hi);
      v  = '0;
      hi = 0;
      for (int i = 0; i < n; i++) begin
         ds_clk = 1'b0;
         wait_clk(HALF);
         if (tri_en === 1'b1) hi++;
         v[i]   = dq_out;
         ds_clk = 1'b1;
         wait_clk(HALF);
      end
   endtask

   task automatic xfer_read(input logic [7:0] op, input int n, output logic [8:0] v,
                            output int hi, output logic tri_after);
      begin_xfer();
      send_bits({1'b0, op}, 8);
      read_bits(n, v, hi);
      tri_after = tri_en;
      end_xfer();
   endtask

   task automatic xfer_write(input logic [7:0] op, input logic [8:0] d, input int n);
      begin_xfer();
      send_bits({1'b0, op}, 8);
      send_bits(d, n);
      end_xfer();
   endtask

   task automatic convert();
      begin_xfer();
      send_bits(9'h0EE, 8);
      end_xfer();
      m_done = 1'b0;
      m_run  = 1'b1;
   endtask

   task automatic wait_conv();
      wait_clk(CONV + 20);
      if (m_run) begin
         m_temp = temp_set;
         m_done = 1'b1;
         if (m_lo[0]) m_run = 1'b0;
         refresh_flags();
      end
   endtask

   task automatic write_cfg(input logic [7:0] d);
      xfer_write(8'h0C, {1'b0, d}, 8);
      m_lo = d[1:0];
      if (!d[6]) m_thf = 1'b0;
      if (!d[5]) m_tlf = 1'b0;
      refresh_flags();
   endtask

   task automatic test_reset();
      logic [8:0] v; int hi; logic ta;
      clr = 1'b1; ds_clk = 1'b1; ds_rst = 1'b0; dq_in = 1'b0; temp_set = '0;
      m_temp = '0; m_lo = '0; m_done = 0; m_run = 0; m_thf = 0; m_tlf = 0;
      m_th = 9'h0F0; m_tl = 9'h1F6;
      wait_clk(1);
      n_cmp++;
      if ({dq_out, tri_en, cmd, cmd_stb, conv_run, thigh, tlow} !== 14'h0) begin
         n_err++;
         $display("FAIL reset_in_clr: got %h required 0", {dq_out, tri_en, cmd, cmd_stb, conv_run, thigh, tlow});
      end
      clr = 1'b0;
      wait_clk(4);
      n_cmp++;
      if ({dq_out, tri_en, cmd, cmd_stb, conv_run, thigh, tlow} !== 14'h0) begin
         n_err++;
         $display("FAIL reset_after: got %h required 0", {dq_out, tri_en, cmd, cmd_stb, conv_run, thigh, tlow});
      end
      xfer_read(8'hAC, 8, v, hi, ta);
      n_cmp++;
      if (v[7:0] !== exp_cfg()) begin
         n_err++; $display("FAIL reset_cfg: got %h required %h", v[7:0], exp_cfg());
      end
   endtask

   task automatic test_convert_read();
      logic [8:0] v; int hi; logic ta; int s0;
      temp_set = 9'h032;
      convert();
      n_cmp++;
      if (conv_run !== 1'b1) begin n_err++; $display("FAIL conv_run_start: got %b required 1", conv_run); end
      wait_conv();
      s0 = stb_count;
      xfer_read(8'hAA, 9, v, hi, ta);
      n_cmp++;
      if (v !== m_temp) begin n_err++; $display("FAIL read_temp_32: got %h required %h", v, m_temp); end
      n_cmp++;
      if ((hi != 9) || (ta !== 1'b0)) begin
         n_err++; $display("FAIL read_tri: got hi=%0d after=%b required hi=9 after=0", hi, ta);
      end
      n_cmp++;
      if ((cmd !== 8'hAA) || (stb_count - s0 != 1)) begin
         n_err++; $display("FAIL cmd_aa: got %h strobes=%0d required AA strobes=1", cmd, stb_count - s0);
      end
   endtask

   task automatic test_negative();
      logic [8:0] v; int hi; logic ta;
      temp_set = 9'h1CE;
      convert();
      wait_conv();
      xfer_read(8'hAA, 9, v, hi, ta);
      n_cmp++;
      if (v !== m_temp) begin n_err++; $display("FAIL read_temp_neg: got %h required %h", v, m_temp); end
      xfer_read(8'hAC, 8, v, hi, ta);
      n_cmp++;
      if (v[7:0] !== exp_cfg()) begin n_err++; $display("FAIL cfg_done: got %h required %h", v[7:0], exp_cfg()); end
   endtask

   task automatic test_oneshot();
      logic [8:0] v; int hi; logic ta;
      write_cfg(8'h03);
      convert();
      wait_clk(20);
      n_cmp++;
      if (conv_run !== 1'b1) begin n_err++; $display("FAIL oneshot_running: got %b required 1", conv_run); end
      wait_conv();
      n_cmp++;
      if (conv_run !== m_run) begin n_err++; $display("FAIL oneshot_stop: got %b required %b", conv_run, m_run); end
      xfer_read(8'hAC, 8, v, hi, ta);
      n_cmp++;
      if (v[7:0] !== exp_cfg()) begin n_err++; $display("FAIL cfg_oneshot: got %h required %h", v[7:0], exp_cfg()); end
   endtask

   task automatic test_abort_cmd();
      logic [8:0] v; int hi; logic ta; int s0;
      s0 = stb_count;
      begin_xfer();
      send_bits(9'h0AA, 4);
      ds_rst = 1'b0;
      wait_clk(SS + 1);
      n_cmp++;
      if ((tri_en !== 1'b0) || (stb_count != s0)) begin
         n_err++; $display("FAIL abort_cmd: got tri=%b strobes=%0d required tri=0 strobes=0", tri_en, stb_count - s0);
      end
      wait_clk(HALF);
      xfer_read(8'hAA, 9, v, hi, ta);
      n_cmp++;
      if (v !== m_temp) begin n_err++; $display("FAIL read_after_abort: got %h required %h", v, m_temp); end
   endtask

   task automatic test_abort_write_read();
      logic [8:0] v; int hi; logic ta;
      begin_xfer();
      send_bits(9'h00C, 8);
      send_bits(9'h000, 5);
      end_xfer();
      xfer_read(8'hAC, 8, v, hi, ta);
      n_cmp++;
      if (v[7:0] !== exp_cfg()) begin n_err++; $display("FAIL partial_write: got %h required %h", v[7:0], exp_cfg()); end
      begin_xfer();
      send_bits(9'h0AA, 8);
      read_bits(4, v, hi);
      ds_rst = 1'b0;
      wait_clk(SS);
      n_cmp++;
      if (tri_en !== 1'b1) begin n_err++; $display("FAIL mid_rd_hold: got %b required 1", tri_en); end
      wait_clk(1);
      n_cmp++;
      if (tri_en !== 1'b0) begin n_err++; $display("FAIL mid_rd_release: got %b required 0", tri_en); end
      n_cmp++;
      if (v[3:0] !== m_temp[3:0]) begin n_err++; $display("FAIL mid_rd_bits: got %h required %h", v[3:0], m_temp[3:0]); end
      wait_clk(HALF);
   endtask

   task automatic test_stop_abort();
      logic [8:0] v; int hi; logic ta;
      temp_set = 9'($urandom);
      convert();
      begin_xfer();
      send_bits(9'h022, 8);
      end_xfer();
      m_run = 1'b0;
      n_cmp++;
      if (conv_run !== 1'b0) begin n_err++; $display("FAIL stop: got %b required 0", conv_run); end
      wait_conv();
      xfer_read(8'hAA, 9, v, hi, ta);
      n_cmp++;
      if (v !== m_temp) begin n_err++; $display("FAIL stop_temp_kept: got %h required %h", v, m_temp); end
      xfer_read(8'hAC, 8, v, hi, ta);
      n_cmp++;
      if (v[7:0] !== exp_cfg()) begin n_err++; $display("FAIL stop_cfg: got %h required %h", v[7:0], exp_cfg()); end
   endtask

   task automatic test_random_conv();
      logic [8:0] v; int hi; logic ta;
      for (int k = 0; k < 6; k++) begin
         temp_set = 9'($urandom);
         convert();
         wait_conv();
         xfer_read(8'hAA, 9, v, hi, ta);
         n_cmp++;
         if (v !== m_temp) begin n_err++; $display("FAIL rand_temp[%0d]: got %h required %h", k, v, m_temp); end
         xfer_read(8'hAC, 8, v, hi, ta);
         n_cmp++;
         if (v[7:0] !== exp_cfg()) begin n_err++; $display("FAIL rand_cfg[%0d]: got %h required %h", k, v[7:0], exp_cfg()); end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] v1, v2, v3; int hi; logic ta; int s0;
      s0 = stb_count;
      xfer_read(8'hAA, 9, v1, hi, ta);
      xfer_read(8'hAC, 8, v2, hi, ta);
      xfer_read(8'hAA, 9, v3, hi, ta);
      n_cmp++;
      if ((v1 !== m_temp) || (v2[7:0] !== exp_cfg()) || (v3 !== m_temp)) begin
         n_err++; $display("FAIL b2b: got %h %h %h required %h %h %h", v1, v2[7:0], v3, m_temp, exp_cfg(), m_temp);
      end
      n_cmp++;
      if ((stb_count - s0 != 3) || (cmd !== 8'hAA)) begin
         n_err++; $display("FAIL b2b_strobes: got %0d cmd %h required 3 cmd AA", stb_count - s0, cmd);
      end
   endtask

   task automatic test_random_cfg();
      logic [8:0] v; int hi; logic ta; logic [7:0] d;
      for (int k = 0; k < 4; k++) begin
         d = 8'($urandom);
         write_cfg(d);
         xfer_read(8'hAC, 8, v, hi, ta);
         n_cmp++;
         if (v[7:0] !== exp_cfg()) begin n_err++; $display("FAIL wr_cfg[%0d]: got %h required %h", k, v[7:0], exp_cfg()); end
      end
   endtask

   task automatic test_unknown();
      logic [8:0] v; int hi; logic ta; logic [7:0] op; int s0;
      for (int k = 0; k < 4; k++) begin
         op = 8'($urandom);
         while (is_known(op)) op = 8'($urandom);
         s0 = stb_count;
         xfer_read(op, 9, v, hi, ta);
         n_cmp++;
         if ((cmd !== op) || (stb_count - s0 != 1) || (hi != 0)) begin
            n_err++; $display("FAIL unknown[%0d]: got cmd=%h strobes=%0d tri=%0d required cmd=%h strobes=1 tri=0",
                              k, cmd, stb_count - s0, hi, op);
         end
      end
   endtask

   task automatic test_thermostat();
      logic [8:0] v; int hi; logic ta;
`ifdef DS1620_THERMOSTAT_EN
      xfer_write(8'h01, 9'h028, 9);
      m_th = 9'h028;
      refresh_flags();
      temp_set = 9'h032;
      convert();
      wait_conv();
      n_cmp++;
      if ({thigh, tlow} !== {($signed(m_temp) >= $signed(m_th)), ($signed(m_temp) <= $signed(m_tl))}) begin
         n_err++; $display("FAIL thermo_flags: got %b%b required %b%b", thigh, tlow,
                           ($signed(m_temp) >= $signed(m_th)), ($signed(m_temp) <= $signed(m_tl)));
      end
      xfer_read(8'hAC, 8, v, hi, ta);
      n_cmp++;
      if (v[7:0] !== exp_cfg()) begin n_err++; $display("FAIL thermo_cfg: got %h required %h", v[7:0], exp_cfg()); end
      xfer_read(8'hA1, 9, v, hi, ta);
      n_cmp++;
      if (v !== m_th) begin n_err++; $display("FAIL read_th: got %h required %h", v, m_th); end
`else
      xfer_read(8'hA1, 9, v, hi, ta);
      n_cmp++;
      if ((hi != 0) || (cmd !== 8'hA1)) begin
         n_err++; $display("FAIL th_absent: got tri=%0d cmd=%h required tri=0 cmd=A1", hi, cmd);
      end
      n_cmp++;
      if ({thigh, tlow} !== 2'b00) begin n_err++; $display("FAIL thermo_off: got %b%b required 00", thigh, tlow); end
`endif
   endtask

   initial begin
      test_reset();
      test_convert_read();
      test_negative();
      test_oneshot();
      test_abort_cmd();
      test_abort_write_read();
      test_stop_abort();
      test_random_conv();
      test_back_to_back();
      test_random_cfg();
      test_unknown();
      test_thermostat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
